lcd_show_char: RTL and testbench

Character renderer that consumes one glyph request from the string/number display controller and paints it onto the LCD pixel by pixel. It latches `ascii_num`, `start_x`, `start_y` and `en_size` on `show_char_flag` and reads glyph rows from an external synchronous font ROM. It streams foreground/background pixels to the LCD write engine over a valid/ready handshake, then pulses `show_char_done` so the controller advances to the next character.

---
 rtl/lcd_show_char_if.sv | 12 +
 rtl/lcd_show_char.sv | 111 +++++++++++
 tb/tb_lcd_show_char.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_show_char_if.sv
// Pixel write stream from the glyph renderer to the LCD write engine.
// One pixel is transferred on each cycle where pix_valid and pix_ready are both high.
interface lcd_show_char_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_color;

  modport master (output pix_valid, pix_x, pix_y, pix_color, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_color, output pix_ready);
endinterface

// File: rtl/lcd_show_char.sv
// Glyph renderer. It latches one character request and fetches each glyph
// row from a synchronous font ROM. Each row is then streamed to the LCD one
// pixel at a time, MSB of the row byte first.
module lcd_show_char #(
  parameter logic [15:0] FG_COLOR    = 16'hFFFF,
  parameter logic [15:0] BG_COLOR    = 16'h0000,
  parameter int          FONT16_BASE = 1140
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              show_char_flag,
  input  logic [6:0]        ascii_num,
  input  logic [8:0]        start_x,
  input  logic [8:0]        start_y,
  input  logic              en_size,
  output logic              rom_rd_en,
  output logic [11:0]       rom_addr,
  input  logic [7:0]        rom_data,
  lcd_show_char_if.master   pix,
  output logic              show_char_done,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, PIX, DONE} state_t;

  typedef struct packed {
    logic [6:0] idx;
    logic [8:0] x0;
    logic [8:0] y0;
    logic       big;   // 1: 16x8 glyph, 0: 12x6 glyph
  } char_req_t;

  state_t     state;
  char_req_t  req;
  logic [3:0] row;
  logic [2:0] col;
  logic [7:0] shreg;

  logic [2:0]  last_col;
  logic [3:0]  last_row;
  logic [11:0] addr12;
  logic [11:0] addr16;

  assign last_col = req.big ? 3'd7  : 3'd5;
  assign last_row = req.big ? 4'd15 : 4'd11;

  // idx*12 = idx*8 + idx*4; idx*16 is a plain shift
  assign addr12 = {2'b00, req.idx, 3'b000} + {3'b000, req.idx, 2'b00} + {8'h00, row};
  assign addr16 = 12'(FONT16_BASE) + {1'b0, req.idx, 4'b0000} + {8'h00, row};

  // Outputs decode the state register; data outputs are forced to 0 outside their state
  assign rom_rd_en      = (state == RD);
  assign rom_addr       = (state == RD) ? (req.big ? addr16 : addr12) : 12'h000;
  assign pix.pix_valid  = (state == PIX);
  assign pix.pix_x      = (state == PIX) ? req.x0 + {6'b000000, col} : 9'h000;
  assign pix.pix_y      = (state == PIX) ? req.y0 + {5'b00000, row} : 9'h000;
  assign pix.pix_color  = (state == PIX) ? (shreg[7] ? FG_COLOR : BG_COLOR) : 16'h0000;
  assign show_char_done = (state == DONE);
  assign busy           = (state != IDLE);

  // Control FSM: row fetch, per-pixel handshake and row/column sequencing
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      req   <= '0;
      row   <= 4'd0;
      col   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (show_char_flag) begin
            // Out-of-table glyph indices fall back to the space glyph
            req.idx <= (ascii_num > 7'd94) ? 7'd0 : ascii_num;
            req.x0  <= start_x;
            req.y0  <= start_y;
            req.big <= en_size;
            row     <= 4'd0;
            col     <= 3'd0;
            state   <= RD;
          end
        end
        RD: state <= WAIT;
        WAIT: begin
          shreg <= rom_data;
          col   <= 3'd0;
          state <= PIX;
        end
        PIX: begin
          if (pix.pix_ready) begin
            shreg <= {shreg[6:0], 1'b0};
            if (col == last_col) begin
              col <= 3'd0;
              if (row == last_row) begin
                state <= DONE;
              end else begin
                row   <= row + 4'd1;
                state <= RD;
              end
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_show_char.sv
// Directed and randomized bench for lcd_show_char. It models a synchronous font ROM.
// The reference builds the expected pixel stream straight from the glyph geometry.
module tb_lcd_show_char;
  localparam logic [15:0] FG  = 16'hF81F;
  localparam logic [15:0] BG  = 16'h07E0;
  localparam int          F16 = 1140;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        show_char_flag = 1'b0;
  logic [6:0]  ascii_num = 7'd0;
  logic [8:0]  start_x = 9'd0;
  logic [8:0]  start_y = 9'd0;
  logic        en_size = 1'b0;
  logic        rom_rd_en;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        show_char_done;
  logic        busy;

  lcd_show_char_if pix_bus();

  lcd_show_char #(.FG_COLOR(FG), .BG_COLOR(BG), .FONT16_BASE(F16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .show_char_flag(show_char_flag),
    .ascii_num(ascii_num), .start_x(start_x), .start_y(start_y), .en_size(en_size),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix(pix_bus), .show_char_done(show_char_done), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Synchronous font ROM: data appears the cycle after the read strobe
  logic [7:0] rom_mem [0:4095];
  always @(posedge sys_clk) if (rom_rd_en) rom_data <= rom_mem[rom_addr];

  int tests = 0;
  int fails = 0;

  // Monitor state, sampled on the falling edge
  int          c0 = 0;
  bit          mon_on = 1'b0;
  logic [33:0] got_pix[$];
  int          got_addr[$];
  int          got_done[$];
  int          stalls = 0;
  int          stab_err = 0;
  bit          prev_stall = 1'b0;
  logic [33:0] prev_pix = '0;
  logic [33:0] cur_pix;

  assign cur_pix = {pix_bus.pix_x, pix_bus.pix_y, pix_bus.pix_color};

  always @(negedge sys_clk) begin
    if (mon_on) begin
      if (prev_stall && !(pix_bus.pix_valid && cur_pix === prev_pix)) stab_err++;
      if (rom_rd_en) got_addr.push_back(int'(rom_addr));
      if (pix_bus.pix_valid && pix_bus.pix_ready) got_pix.push_back(cur_pix);
      if (pix_bus.pix_valid && !pix_bus.pix_ready) stalls++;
      prev_stall = pix_bus.pix_valid && !pix_bus.pix_ready;
      prev_pix   = cur_pix;
      if (show_char_done) got_done.push_back(cyc - c0);
    end
  end

  logic [33:0] exp_pix[$];
  int          exp_addr[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: raster walk over the glyph box, one ROM byte per row, MSB leftmost
  task automatic build_model(input int idx, input int sx, input int sy, input bit sz);
    int id, rows, cols, a;
    logic [7:0] b;
    exp_pix.delete();
    exp_addr.delete();
    id   = (idx > 94) ? 0 : idx;
    rows = sz ? 16 : 12;
    cols = sz ? 8 : 6;
    for (int r = 0; r < rows; r++) begin
      a = sz ? (F16 + id * 16 + r) : (id * 12 + r);
      exp_addr.push_back(a);
      b = rom_mem[a];
      for (int c = 0; c < cols; c++)
        exp_pix.push_back({9'((sx + c) % 512), 9'((sy + r) % 512), b[7 - c] ? FG : BG});
    end
  endtask

  task automatic clear_mon();
    got_pix.delete();
    got_addr.delete();
    got_done.delete();
    stalls = 0;
    stab_err = 0;
    prev_stall = 1'b0;
  endtask

  task automatic fill_rom(input bit rnd, input logic [7:0] v);
    for (int i = 0; i < 4096; i++) rom_mem[i] = rnd ? 8'($urandom) : v;
  endtask

  // mode 0: ready high, 1: toggle every cycle, 2: random ready
  task automatic run_char(input string name, input int idx, input int sx, input int sy,
                          input bit sz, input int mode, input int flag_at1, input int flag_at2);
    int rel, n, bad, first_bad;
    bit seen;
    build_model(idx, sx, sy, sz);
    clear_mon();
    @(posedge sys_clk); #1;
    show_char_flag = 1'b1;
    ascii_num = 7'(idx);
    start_x = 9'(sx);
    start_y = 9'(sy);
    en_size = sz;
    c0 = cyc;
    mon_on = 1'b1;
    rel = 0;
    seen = 1'b0;
    while (!seen && rel < 700) begin
      @(posedge sys_clk); #1;
      rel = cyc - c0;
      show_char_flag = (rel == flag_at1) || (rel == flag_at2);
      if (show_char_flag) ascii_num = 7'd5;
      case (mode)
        0:       pix_bus.pix_ready = 1'b1;
        1:       pix_bus.pix_ready = rel[0];
        default: pix_bus.pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (got_done.size() > 0) seen = 1'b1;
    end
    show_char_flag = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    check({name, " done_count"}, got_done.size(), 1);
    check({name, " done_cycle"}, (got_done.size() > 0) ? got_done[0] : -1,
          (sz ? 161 : 97) + stalls);
    check({name, " pix_count"}, got_pix.size(), exp_pix.size());
    check({name, " addr_count"}, got_addr.size(), exp_addr.size());
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++)
      if (got_pix[i] !== exp_pix[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    if (first_bad >= 0) check({name, " first_bad_pixel"}, got_pix[first_bad], exp_pix[first_bad]);
    check({name, " pix_mismatches"}, bad, 0);
    bad = 0;
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if (got_addr[i] != exp_addr[i]) bad++;
    check({name, " addr_mismatches"}, bad, 0);
    check({name, " stall_stability"}, stab_err, 0);
    check({name, " idle_after"}, busy, 0);
    mon_on = 1'b0;
  endtask

  initial begin
    int n;
    fill_rom(1'b1, 8'h00);
    pix_bus.pix_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_outputs",
          {rom_rd_en, rom_addr, pix_bus.pix_valid, pix_bus.pix_x, pix_bus.pix_y,
           pix_bus.pix_color, show_char_done, busy}, 64'd0);
    sys_rst_n = 1'b1;

    // 'A' in the 12x6 font with every row byte 8'hA4
    fill_rom(1'b0, 8'hA4);
    run_char("a12", 33, 8, 48, 1'b0, 0, -1, -1);
    if (got_pix.size() >= 72) begin
      check("a12 row0_colors",
            {got_pix[0][15:0], got_pix[1][15:0], got_pix[2][15:0],
             got_pix[3][15:0]}, {FG, BG, FG, BG});
      check("a12 row0_tail", {got_pix[4][15:0], got_pix[5][15:0]}, {BG, FG});
      check("a12 first_xy", got_pix[0][33:16], {9'd8, 9'd48});
      check("a12 last_y", got_pix[71][24:16], 9'd59);
    end

    fill_rom(1'b1, 8'h00);
    run_char("b16", 50, 72, 16, 1'b1, 0, -1, -1);
    if (got_addr.size() >= 16) begin
      check("b16 addr_first", got_addr[0], 1940);
      check("b16 addr_last", got_addr[15], 1955);
    end
    if (got_pix.size() >= 128) check("b16 last_xy", got_pix[127][33:16], {9'd79, 9'd31});

    // Backpressure
    run_char("bp_toggle", $urandom_range(0, 94), $urandom_range(0, 511), $urandom_range(0, 511),
             1'b0, 1, -1, -1);
    check("bp_toggle stalls_seen", stalls > 0, 1);
    run_char("bp_random", $urandom_range(0, 94), $urandom_range(0, 511), $urandom_range(0, 511),
             1'b1, 2, -1, -1);

    // Coordinate wrap on both axes
    run_char("wrap", 17, 508, 500, 1'b1, 0, -1, -1);
    if (got_pix.size() >= 128) begin
      check("wrap x3", got_pix[3][33:25], 9'd511);
      check("wrap x4", got_pix[4][33:25], 9'd0);
      check("wrap last_xy", got_pix[127][33:16], {9'd3, 9'd3});
    end

    // Flag while busy (mid-glyph and in the DONE cycle) must be dropped
    run_char("busy_flag", 40, 100, 100, 1'b0, 0, 20, 97);
    run_char("clamp", 120, 30, 30, 1'b0, 0, -1, -1);
    if (got_addr.size() > 0) check("clamp addr0", got_addr[0], 0);

    // Reset mid-glyph
    build_model(60, 200, 10, 1'b1);
    clear_mon();
    @(posedge sys_clk); #1;
    show_char_flag = 1'b1;
    ascii_num = 7'd60;
    start_x = 9'd200;
    start_y = 9'd10;
    en_size = 1'b1;
    pix_bus.pix_ready = 1'b1;
    c0 = cyc;
    mon_on = 1'b1;
    @(posedge sys_clk); #1;
    show_char_flag = 1'b0;
    n = 0;
    while (got_pix.size() < 30 && n < 400) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check("rst reached_pixel30", got_pix.size() >= 30, 1);
    sys_rst_n = 1'b0;
    #1;
    check("rst outputs_now",
          {rom_rd_en, rom_addr, pix_bus.pix_valid, pix_bus.pix_x, pix_bus.pix_y,
           pix_bus.pix_color, show_char_done, busy}, 64'd0);
    repeat (3) @(negedge sys_clk);
    check("rst outputs_held",
          {rom_rd_en, rom_addr, pix_bus.pix_valid, pix_bus.pix_x, pix_bus.pix_y,
           pix_bus.pix_color, show_char_done, busy}, 64'd0);
    check("rst no_done", got_done.size(), 0);
    mon_on = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    run_char("after_rst", 60, 200, 10, 1'b1, 0, -1, -1);

    // Random glyphs, positions, sizes and ready patterns
    for (int k = 0; k < 4; k++)
      run_char("rand", $urandom_range(0, 127), $urandom_range(0, 511), $urandom_range(0, 511),
               1'($urandom_range(0, 1)), 2, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
